// File: rtl/seq_det_sched.sv
// Shared serial-pattern detector time-multiplexed over NCH bit-serial channels.
// Round-robin grant feeds one comparator; each channel keeps its own history, fill and match count.
module seq_det_sched #(
    parameter int unsigned NCH    = 4,
    parameter int unsigned MAXLEN = 8,
    parameter int unsigned CW     = 16,
    localparam int unsigned CHW   = $clog2(NCH),
    localparam int unsigned LW    = $clog2(MAXLEN + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              cfg_we,
    input  logic [MAXLEN-1:0] cfg_pattern,
    input  logic [LW-1:0]     cfg_len,
    output logic              cfg_err,
    input  logic [NCH-1:0]    ch_valid,
    input  logic [NCH-1:0]    ch_bit,
    output logic [NCH-1:0]    ch_ready,
    output logic              det_valid,
    output logic [CHW-1:0]    det_ch,
    input  logic              cnt_clr,
    input  logic [CHW-1:0]    rd_ch,
    output logic [CW-1:0]     rd_cnt
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [CHW-1:0]    ptr_q;
    logic [MAXLEN-1:0] pattern_q;
    logic [LW-1:0]     len_q;
    logic [MAXLEN-1:0] hist_q [NCH];
    logic [LW-1:0]     fill_q [NCH];
    logic [CW-1:0]     cnt_q  [NCH];
    logic              det_valid_q;
    logic [CHW-1:0]    det_ch_q;
    logic              cfg_err_q;

    logic              gnt_any_c;
    logic [CHW-1:0]    gnt_idx_c;
    logic [NCH-1:0]    grant_c;
    logic [CHW-1:0]    ptr_d;
    logic [MAXLEN-1:0] hist_new_c;
    logic [LW-1:0]     fill_new_c;
    logic [MAXLEN-1:0] mask_c;
    logic              match_c;
    logic              cfg_ok_c;

    // Round-robin search: first valid channel at or after the pointer, wrapping.
    always_comb begin
        logic [CHW:0] sum;
        sum       = '0;
        gnt_any_c = 1'b0;
        gnt_idx_c = '0;
        grant_c   = '0;
        for (int i = 0; i < NCH; i++) begin
            sum = {1'b0, ptr_q} + (CHW+1)'(i);
            if (sum >= (CHW+1)'(NCH)) begin
                sum = sum - (CHW+1)'(NCH);
            end
            if (en && !gnt_any_c && ch_valid[sum[CHW-1:0]]) begin
                gnt_any_c = 1'b1;
                gnt_idx_c = sum[CHW-1:0];
            end
        end
        if (gnt_any_c) begin
            grant_c[gnt_idx_c] = 1'b1;
        end
        ptr_d = (gnt_idx_c == CHW'(NCH - 1)) ? '0 : gnt_idx_c + CHW'(1);
    end

    // Comparator works on the granted channel's post-shift context.
    always_comb begin
        hist_new_c = {hist_q[gnt_idx_c][MAXLEN-2:0], ch_bit[gnt_idx_c]};
        fill_new_c = (fill_q[gnt_idx_c] == LW'(MAXLEN)) ? fill_q[gnt_idx_c]
                                                        : fill_q[gnt_idx_c] + LW'(1);
        mask_c = '0;
        for (int b = 0; b < MAXLEN; b++) begin
            mask_c[b] = (b < int'(len_q));
        end
        match_c = gnt_any_c && (len_q != '0) && (fill_new_c >= len_q) &&
                  (((hist_new_c ^ pattern_q) & mask_c) == '0);
        cfg_ok_c = cfg_we && !en && (cfg_len != '0) && (cfg_len <= LW'(MAXLEN));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            pattern_q   <= '0;
            len_q       <= '0;
            det_valid_q <= 1'b0;
            det_ch_q    <= '0;
            cfg_err_q   <= 1'b0;
            for (int g = 0; g < NCH; g++) begin
                hist_q[g] <= '0;
                fill_q[g] <= '0;
                cnt_q[g]  <= '0;
            end
        end else begin
            cfg_err_q   <= cfg_we && !cfg_ok_c;
            det_valid_q <= match_c;
            if (match_c) begin
                det_ch_q <= gnt_idx_c;
            end
            if (gnt_any_c) begin
                ptr_q <= ptr_d;
            end
            if (cfg_ok_c) begin
                pattern_q <= cfg_pattern;
                len_q     <= cfg_len;
            end
            for (int g = 0; g < NCH; g++) begin
                if (!en || cfg_ok_c) begin
                    hist_q[g] <= '0;
                    fill_q[g] <= '0;
                end else if (gnt_any_c && (gnt_idx_c == CHW'(g))) begin
                    hist_q[g] <= hist_new_c;
                    fill_q[g] <= fill_new_c;
                end
                // Clear has priority over a coincident match.
                if (cnt_clr) begin
                    cnt_q[g] <= '0;
                end else if (match_c && (gnt_idx_c == CHW'(g)) && (cnt_q[g] != CNT_MAX)) begin
                    cnt_q[g] <= cnt_q[g] + CW'(1);
                end
            end
        end
    end

    assign ch_ready  = grant_c;
    assign det_valid = det_valid_q;
    assign det_ch    = det_ch_q;
    assign cfg_err   = cfg_err_q;
    assign rd_cnt    = cnt_q[rd_ch];

endmodule

// File: tb/tb_seq_det_sched.sv
// Bench for seq_det_sched: directed vector table, hand sequences, then random traffic
// checked against a queue-based reference model (two instances: CW=16 and CW=4).
module tb_seq_det_sched;

    localparam int NCH    = 4;
    localparam int MAXLEN = 8;
    localparam int CHW    = 2;
    localparam int LW     = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n, en, cfg_we, cnt_clr;
    logic [MAXLEN-1:0] cfg_pattern;
    logic [LW-1:0]     cfg_len;
    logic [NCH-1:0]    ch_valid, ch_bit;
    logic [CHW-1:0]    rd_ch;

    logic              cfg_err, det_valid, cfg_err4, det_valid4;
    logic [NCH-1:0]    ch_ready, ch_ready4;
    logic [CHW-1:0]    det_ch, det_ch4;
    logic [15:0]       rd_cnt;
    logic [3:0]        rd_cnt4;

    seq_det_sched #(.NCH(NCH), .MAXLEN(MAXLEN), .CW(16)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_err(cfg_err), .ch_valid(ch_valid), .ch_bit(ch_bit),
        .ch_ready(ch_ready), .det_valid(det_valid), .det_ch(det_ch), .cnt_clr(cnt_clr),
        .rd_ch(rd_ch), .rd_cnt(rd_cnt));

    seq_det_sched #(.NCH(NCH), .MAXLEN(MAXLEN), .CW(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_err(cfg_err4), .ch_valid(ch_valid), .ch_bit(ch_bit),
        .ch_ready(ch_ready4), .det_valid(det_valid4), .det_ch(det_ch4), .cnt_clr(cnt_clr),
        .rd_ch(rd_ch), .rd_cnt(rd_cnt4));

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: bit queues per channel, unbounded raw match count.
    int         m_ptr, m_len;
    logic [7:0] m_pat;
    bit         m_hist [NCH][$];
    int         m_raw  [NCH];
    bit         e_det, e_err;
    int         e_ch;

    function automatic int m_grant();
        if (!en) return -1;
        for (int i = 0; i < NCH; i++) begin
            if (ch_valid[(m_ptr + i) % NCH]) return (m_ptr + i) % NCH;
        end
        return -1;
    endfunction

    function automatic int cap(input int v, input int w);
        return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
    endfunction

    task automatic m_clear_hist();
        for (int c = 0; c < NCH; c++) m_hist[c].delete();
    endtask

    task automatic m_step();
        int g;
        bit match;
        g = m_grant();
        match = 1'b0;
        if (!rst_n) begin
            m_ptr = 0; m_len = 0; m_pat = '0;
            m_clear_hist();
            for (int c = 0; c < NCH; c++) m_raw[c] = 0;
            e_det = 0; e_ch = 0; e_err = 0;
            return;
        end
        if (g >= 0) begin
            m_hist[g].push_back(ch_bit[g]);
            if (m_hist[g].size() > MAXLEN) void'(m_hist[g].pop_front());
            if (m_len > 0 && m_hist[g].size() >= m_len) begin
                match = 1'b1;
                for (int k = 0; k < m_len; k++) begin
                    if (m_hist[g][m_hist[g].size() - 1 - k] != m_pat[k]) match = 1'b0;
                end
            end
            m_ptr = (g + 1) % NCH;
        end
        if (!en) m_clear_hist();
        e_err = 1'b0;
        if (cfg_we) begin
            if (!en && cfg_len >= 1 && cfg_len <= MAXLEN) begin
                m_pat = cfg_pattern;
                m_len = int'(cfg_len);
                m_clear_hist();
            end else begin
                e_err = 1'b1;
            end
        end
        if (cnt_clr) begin
            for (int c = 0; c < NCH; c++) m_raw[c] = 0;
        end else if (match) begin
            m_raw[g]++;
        end
        e_det = match;
        if (match) e_ch = g;
    endtask

    // One clock: optional model check of grant, edge, model update, optional output checks.
    task automatic tick(input bit mchk);
        int g;
        logic [NCH-1:0] eg;
        #1;
        g  = m_grant();
        eg = (g >= 0) ? (NCH'(1) << g) : '0;
        if (mchk) chk("rand_ready", longint'(ch_ready), longint'(eg));
        @(posedge clk);
        m_step();
        #1;
        if (mchk) begin
            chk("rand_det_valid", longint'(det_valid), longint'(e_det));
            if (e_det) chk("rand_det_ch", longint'(det_ch), longint'(e_ch));
            chk("rand_cfg_err", longint'(cfg_err), longint'(e_err));
            chk("rand_cnt16", longint'(rd_cnt), longint'(cap(m_raw[rd_ch], 16)));
            chk("rand_cnt4", longint'(rd_cnt4), longint'(cap(m_raw[rd_ch], 4)));
        end
    endtask

    typedef struct {
        bit en, we;
        int pat, len, v, b;
        bit clr;
        int rdy;
        bit det;
        int ch;
        bit err;
        int cnt;
    } vec_t;
    vec_t tbl[$];

    task automatic row(input bit r_en, input bit r_we, input int r_pat, input int r_len,
                       input int r_v, input int r_b, input bit r_clr, input int r_rdy,
                       input bit r_det, input int r_ch, input bit r_err, input int r_cnt);
        vec_t r;
        r = '{r_en, r_we, r_pat, r_len, r_v, r_b, r_clr, r_rdy, r_det, r_ch, r_err, r_cnt};
        tbl.push_back(r);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; cfg_we = 1'b0; cnt_clr = 1'b0;
        cfg_pattern = '0; cfg_len = '0; ch_valid = '0; ch_bit = '0; rd_ch = '0;
        tick(0);
        tick(0);
        chk("reset_det_valid", longint'(det_valid), 0);
        chk("reset_cfg_err", longint'(cfg_err), 0);
        chk("reset_cnt", longint'(rd_cnt), 0);
        chk("reset_ready", longint'(ch_ready), 0);
        rst_n = 1'b1;

        //   en we pat len   v    b  clr rdy det ch err cnt
        row(0, 1, 5, 3,    0,   0,   0,  0,  0, 0, 0, 0);
        row(0, 1, 5, 0,    0,   0,   0,  0,  0, 0, 1, 0);
        row(0, 1, 5, 9,    0,   0,   0,  0,  0, 0, 1, 0);
        row(1, 1, 3, 2,    0,   0,   0,  0,  0, 0, 1, 0);
        row(1, 0, 0, 0,    1,   1,   0,  1,  0, 0, 0, 0);
        row(1, 0, 0, 0,    1,   0,   0,  1,  0, 0, 0, 0);
        row(1, 0, 0, 0,    1,   1,   0,  1,  1, 0, 0, 1);
        row(1, 0, 0, 0,    1,   0,   0,  1,  0, 0, 0, 1);
        row(1, 0, 0, 0,    1,   1,   0,  1,  1, 0, 0, 2);
        row(1, 0, 0, 0,    15,  0,   0,  2,  0, 0, 0, 2);
        row(1, 0, 0, 0,    15,  0,   0,  4,  0, 0, 0, 2);
        row(1, 0, 0, 0,    15,  0,   0,  8,  0, 0, 0, 2);
        row(1, 0, 0, 0,    15,  0,   0,  1,  0, 0, 0, 2);
        row(1, 0, 0, 0,    15,  0,   0,  2,  0, 0, 0, 2);
        row(1, 0, 0, 0,    11,  0,   0,  8,  0, 0, 0, 2);
        row(0, 0, 0, 0,    15,  0,   0,  0,  0, 0, 0, 2);
        row(1, 0, 0, 0,    1,   1,   0,  1,  0, 0, 0, 2);
        row(1, 0, 0, 0,    1,   0,   0,  1,  0, 0, 0, 2);
        row(0, 0, 0, 0,    0,   0,   0,  0,  0, 0, 0, 2);
        row(1, 0, 0, 0,    1,   1,   0,  1,  0, 0, 0, 2);
        row(0, 1, 0, 3,    0,   0,   0,  0,  0, 0, 0, 2);
        row(1, 0, 0, 0,    2,   0,   0,  2,  0, 0, 0, 2);
        row(1, 0, 0, 0,    4,   4,   0,  4,  0, 0, 0, 2);
        row(1, 0, 0, 0,    2,   0,   0,  2,  0, 0, 0, 2);
        row(1, 0, 0, 0,    4,   0,   0,  4,  0, 0, 0, 2);
        row(1, 0, 0, 0,    2,   0,   0,  2,  1, 1, 0, 2);
        row(1, 0, 0, 0,    4,   0,   0,  4,  0, 0, 0, 2);
        row(1, 0, 0, 0,    4,   0,   0,  4,  1, 2, 0, 2);
        row(1, 0, 0, 0,    4,   0,   1,  4,  1, 2, 0, 0);

        foreach (tbl[i]) begin
            en = tbl[i].en; cfg_we = tbl[i].we;
            cfg_pattern = 8'(tbl[i].pat); cfg_len = 4'(tbl[i].len);
            ch_valid = 4'(tbl[i].v); ch_bit = 4'(tbl[i].b); cnt_clr = tbl[i].clr; rd_ch = '0;
            #1;
            chk($sformatf("tbl%0d_ready", i), longint'(ch_ready), longint'(tbl[i].rdy));
            tick(0);
            chk($sformatf("tbl%0d_det_valid", i), longint'(det_valid), longint'(tbl[i].det));
            if (tbl[i].det) chk($sformatf("tbl%0d_det_ch", i), longint'(det_ch), longint'(tbl[i].ch));
            chk($sformatf("tbl%0d_cfg_err", i), longint'(cfg_err), longint'(tbl[i].err));
            chk($sformatf("tbl%0d_cnt", i), longint'(rd_cnt), longint'(tbl[i].cnt));
        end

        // Saturation: single-bit pattern "1", 17 matches on ch3.
        en = 1'b0; cfg_we = 1'b1; cfg_pattern = 8'h01; cfg_len = 4'd1;
        cnt_clr = 1'b0; ch_valid = '0; ch_bit = '0; rd_ch = 2'd3;
        tick(0);
        cfg_we = 1'b0; en = 1'b1; ch_valid = 4'b1000; ch_bit = 4'b1000;
        for (int i = 0; i < 17; i++) tick(0);
        chk("sat_det_ch", longint'(det_ch), 3);
        chk("sat_cnt4", longint'(rd_cnt4), 15);
        chk("sat_cnt16", longint'(rd_cnt), 17);
        cnt_clr = 1'b1;
        tick(0);
        chk("clr_vs_match_det", longint'(det_valid), 1);
        chk("clr_vs_match_cnt4", longint'(rd_cnt4), 0);
        chk("clr_vs_match_cnt16", longint'(rd_cnt), 0);
        cnt_clr = 1'b0;
        tick(0);
        chk("post_clr_cnt16", longint'(rd_cnt), 1);

        // Reset mid-stream drops the match that would otherwise register.
        rst_n = 1'b0;
        tick(0);
        chk("midrst_det_valid", longint'(det_valid), 0);
        chk("midrst_cnt", longint'(rd_cnt), 0);
        rst_n = 1'b1;
        tick(0);
        chk("midrst_len0_nomatch", longint'(det_valid), 0);

        // Random traffic against the model.
        en = 1'b0; cfg_we = 1'b1; cfg_pattern = 8'h02; cfg_len = 4'd2; ch_valid = '0;
        tick(1);
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom % 600) != 0;
            if ($urandom % 40 == 0) en = ~en;
            cfg_we = ($urandom % 20) == 0;
            cfg_pattern = 8'($urandom);
            cfg_len = ($urandom % 4 == 0) ? 4'($urandom_range(0, MAXLEN + 1))
                                          : 4'($urandom_range(1, 3));
            ch_valid = 4'($urandom);
            ch_bit = 4'($urandom);
            cnt_clr = ($urandom % 150) == 0;
            rd_ch = 2'($urandom);
            tick(1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
